// File: rtl/mem_pkg.sv
// Shared types, constants and address helpers for the memory responder.
package mem_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef enum logic [1:0] {RD_ZERO, RD_RAM, RD_MMIO} rd_sel_t;

  // Word index of the memory-mapped output register: all-ones index.
  function automatic logic [31:0] mmio_index(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

  // Misaligned, or byte address beyond the 2^aw-word RAM.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/mem_ram.sv
// Single-port synchronous RAM, write enable, registered read, no reset.
module mem_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, WAIT_CYCLES wait states, one-cycle response.
// Optional output register at the top RAM word when MEM_RESPONDER_MMIO_EN is defined.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic              req_ifetch,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              rsp_valid,
  output logic              rsp_ifetch,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [DATA_W-1:0] mmio_out
);

  state_t            state, state_nx;
  logic [3:0]        wait_cnt;
  logic              we_q, ifetch_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              c_we, c_ifetch, c_err, c_mmio, commit, ram_we;
  logic [31:0]       c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [ADDR_W-1:0] c_idx;
  logic [DATA_W-1:0] ram_rdata, mmio_q;
  rd_sel_t           rd_sel;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (wait_cnt == '0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // With zero wait states the commit edge is the accept edge, so the live
    // request is used while still in IDLE; otherwise the latched copy.
    c_we     = (state == IDLE) ? req_we     : we_q;
    c_ifetch = (state == IDLE) ? req_ifetch : ifetch_q;
    c_addr   = (state == IDLE) ? req_addr   : addr_q;
    c_wdata  = (state == IDLE) ? req_wdata  : wdata_q;
    c_idx    = c_addr[ADDR_W+1:2];
    c_err    = addr_err(c_addr, ADDR_W);
    commit   = (state_nx == RESP) && !reset;
`ifdef MEM_RESPONDER_MMIO_EN
    c_mmio   = (c_idx == ADDR_W'(mmio_index(ADDR_W)));
`else
    c_mmio   = 1'b0;
`endif
    ram_we   = commit && c_we && !c_err && !c_mmio;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_ifetch <= 1'b0;
      rsp_err    <= 1'b0;
      rd_sel     <= RD_ZERO;
      we_q       <= 1'b0;
      ifetch_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state     <= state_nx;
      busy      <= (state_nx != IDLE);
      rsp_valid <= commit;
      if (state == IDLE && req_valid) begin
        we_q     <= req_we;
        ifetch_q <= req_ifetch;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        if (WAIT_CYCLES > 0) wait_cnt <= 4'(WAIT_CYCLES - 1);
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      rsp_ifetch <= commit ? c_ifetch : 1'b0;
      rsp_err    <= commit ? c_err : 1'b0;
      if (!commit || c_err || c_we) rd_sel <= RD_ZERO;
      else if (c_mmio)              rd_sel <= RD_MMIO;
      else                          rd_sel <= RD_RAM;
    end
  end

`ifdef MEM_RESPONDER_MMIO_EN
  always_ff @(posedge clk) begin
    if (reset)                                 mmio_q <= '0;
    else if (commit && c_we && !c_err && c_mmio) mmio_q <= c_wdata;
  end
`else
  assign mmio_q = '0;
`endif

  assign mmio_out = mmio_q;

  always_comb begin
    rsp_rdata = '0;
    case (rd_sel)
      RD_RAM:  rsp_rdata = ram_rdata;
      RD_MMIO: rsp_rdata = mmio_q;
      default: rsp_rdata = '0;
    endcase
  end

  mem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (c_idx),
    .wdata (c_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: three responders (0, 1 and 3 wait states) driven with identical requests.
module tb_mem_responder;

  logic        clk;
  logic        reset, rst3, rst_u3;
  logic        req_valid, req_we, req_ifetch;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  busy_v, valid_v, err_v, ifetch_v;
  logic [31:0] rdata_v [3];
  logic [31:0] mmio_v  [3];

  int unsigned wc [3] = '{0, 1, 3};
  int          vectors = 0;
  int          miscompares = 0;

  int          first_v [3];
  int          nv      [3];
  int          nbusy   [3];
  logic [31:0] rd      [3];
  logic        er      [3];
  logic        fi      [3];
  logic [31:0] mm      [3][8];
  logic        bz      [3][8];

`ifdef MEM_RESPONDER_MMIO_EN
  localparam logic [31:0] EXP_MMIO = 32'h0000_00A5;
`else
  localparam logic [31:0] EXP_MMIO = 32'h0000_0000;
`endif

  assign rst_u3 = reset | rst3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_ifetch(req_ifetch), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy_v[0]), .rsp_valid(valid_v[0]), .rsp_ifetch(ifetch_v[0]),
    .rsp_err(err_v[0]), .rsp_rdata(rdata_v[0]), .mmio_out(mmio_v[0]));

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_ifetch(req_ifetch), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy_v[1]), .rsp_valid(valid_v[1]), .rsp_ifetch(ifetch_v[1]),
    .rsp_err(err_v[1]), .rsp_rdata(rdata_v[1]), .mmio_out(mmio_v[1]));

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(rst_u3), .req_valid(req_valid), .req_we(req_we),
    .req_ifetch(req_ifetch), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy_v[2]), .rsp_valid(valid_v[2]), .rsp_ifetch(ifetch_v[2]),
    .rsp_err(err_v[2]), .rsp_rdata(rdata_v[2]), .mmio_out(mmio_v[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called right after a negedge with all responders idle; pulses one request
  // and records cycles 1..7 after the accept edge.
  task automatic txn(input logic we, input logic ifetch, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit dup, input logic [31:0] dup_addr,
                     input logic [31:0] dup_wdata, input int rst3_at);
    for (int i = 0; i < 3; i++) begin
      first_v[i] = 0; nv[i] = 0; nbusy[i] = 0; rd[i] = '0; er[i] = 1'b0; fi[i] = 1'b0;
    end
    req_valid = 1'b1; req_we = we; req_ifetch = ifetch; req_addr = addr; req_wdata = wdata;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (busy_v[i]) nbusy[i]++;
        if (valid_v[i]) begin
          nv[i]++;
          if (first_v[i] == 0) begin
            first_v[i] = k; rd[i] = rdata_v[i]; er[i] = err_v[i]; fi[i] = ifetch_v[i];
          end
        end
        mm[i][k] = mmio_v[i];
        bz[i][k] = busy_v[i];
      end
      if (k == 1 && dup) begin
        req_valid = 1'b1; req_we = 1'b1; req_ifetch = 1'b0;
        req_addr = dup_addr; req_wdata = dup_wdata;
      end else begin
        req_valid = 1'b0;
      end
      if (k == rst3_at) rst3 = 1'b1;
      else if (k == rst3_at + 1) rst3 = 1'b0;
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] exp_rd, input logic exp_err,
                         input logic exp_if, input logic [2:0] mask);
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        chk($sformatf("%s w%0d latency", tag, wc[i]), first_v[i], wc[i] + 1);
        chk($sformatf("%s w%0d strobes", tag, wc[i]), nv[i], 1);
        chk($sformatf("%s w%0d busy_cycles", tag, wc[i]), nbusy[i], wc[i] + 1);
        chk($sformatf("%s w%0d rdata", tag, wc[i]), rd[i], exp_rd);
        chk($sformatf("%s w%0d err", tag, wc[i]), {31'd0, er[i]}, {31'd0, exp_err});
        chk($sformatf("%s w%0d ifetch", tag, wc[i]), {31'd0, fi[i]}, {31'd0, exp_if});
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rst3 = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_ifetch = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset w%0d busy", wc[i]), {31'd0, busy_v[i]}, 32'd0);
      chk($sformatf("reset w%0d rsp_valid", wc[i]), {31'd0, valid_v[i]}, 32'd0);
      chk($sformatf("reset w%0d rsp_err", wc[i]), {31'd0, err_v[i]}, 32'd0);
      chk($sformatf("reset w%0d rsp_ifetch", wc[i]), {31'd0, ifetch_v[i]}, 32'd0);
      chk($sformatf("reset w%0d rsp_rdata", wc[i]), rdata_v[i], 32'd0);
      chk($sformatf("reset w%0d mmio_out", wc[i]), mmio_v[i], 32'd0);
    end

    txn(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, '0, '0, 0);
    chk_rsp("store_10", 32'h0, 1'b0, 1'b0, 3'b111);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, '0, '0, 0);
    chk_rsp("load_10", 32'hDEAD_BEEF, 1'b0, 1'b0, 3'b111);

    txn(1'b1, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0, '0, '0, 0);
    chk_rsp("store_0", 32'h0, 1'b0, 1'b0, 3'b111);
    txn(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, '0, '0, 0);
    chk_rsp("fetch_0", 32'h0BAD_F00D, 1'b0, 1'b1, 3'b111);

    txn(1'b0, 1'b0, 32'h6, 32'h0, 1'b0, '0, '0, 0);
    chk_rsp("load_misaligned", 32'h0, 1'b1, 1'b0, 3'b111);
    txn(1'b0, 1'b0, 32'h1000, 32'h0, 1'b0, '0, '0, 0);
    chk_rsp("load_out_of_range", 32'h0, 1'b1, 1'b0, 3'b111);
    txn(1'b1, 1'b0, 32'h2, 32'hFFFF_FFFF, 1'b0, '0, '0, 0);
    chk_rsp("store_misaligned", 32'h0, 1'b1, 1'b0, 3'b111);
    txn(1'b1, 1'b0, 32'h1000, 32'hFFFF_FFFF, 1'b0, '0, '0, 0);
    chk_rsp("store_out_of_range", 32'h0, 1'b1, 1'b0, 3'b111);
    txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, '0, '0, 0);
    chk_rsp("load_0_after_errs", 32'h0BAD_F00D, 1'b0, 1'b0, 3'b111);

    txn(1'b1, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b0, '0, '0, 0);
    chk_rsp("store_20", 32'h0, 1'b0, 1'b0, 3'b111);
    txn(1'b1, 1'b0, 32'h10, 32'h1111_1111, 1'b1, 32'h20, 32'h2222_2222, 0);
    chk_rsp("store_with_dropped", 32'h0, 1'b0, 1'b0, 3'b111);
    txn(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, '0, '0, 0);
    chk_rsp("load_20_after_drop", 32'hCAFE_F00D, 1'b0, 1'b0, 3'b111);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, '0, '0, 0);
    chk_rsp("load_10_raw", 32'h1111_1111, 1'b0, 1'b0, 3'b111);

    txn(1'b1, 1'b0, 32'h20, 32'h1234_5678, 1'b0, '0, '0, 2);
    chk_rsp("store_20_reset", 32'h0, 1'b0, 1'b0, 3'b011);
    chk("store_20_reset w3 strobes", nv[2], 0);
    chk("store_20_reset w3 busy_after_reset", {31'd0, bz[2][3]}, 32'd0);
    txn(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, '0, '0, 0);
    chk_rsp("load_20_committed", 32'h1234_5678, 1'b0, 1'b0, 3'b011);
    chk_rsp("load_20_uncommitted", 32'hCAFE_F00D, 1'b0, 1'b0, 3'b100);

    txn(1'b1, 1'b0, 32'hFFC, 32'h0000_00A5, 1'b0, '0, '0, 0);
    chk_rsp("store_ffc", 32'h0, 1'b0, 1'b0, 3'b111);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mmio w%0d after_commit", wc[i]), mm[i][wc[i] + 1], EXP_MMIO);
      if (wc[i] > 0) chk($sformatf("mmio w%0d before_commit", wc[i]), mm[i][wc[i]], 32'h0);
    end
    txn(1'b0, 1'b0, 32'hFFC, 32'h0, 1'b0, '0, '0, 0);
    chk_rsp("load_ffc", 32'h0000_00A5, 1'b0, 1'b0, 3'b111);
    for (int i = 0; i < 3; i++)
      chk($sformatf("mmio w%0d final", wc[i]), mmio_v[i], EXP_MMIO);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multi-cycle CPU's single memory port. It accepts one word-sized fetch, load or store request at a time from the CPU control path, inserts a configurable number of wait states, and commits the write or returns the read data with a one-cycle response strobe. It owns the unified instruction/data RAM and an optional memory-mapped output register. It sits between the CPU datapath and the RAM.

## Interface
Parameters:
- ADDR_W, 10: word-index width; RAM holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 1: wait states between accept and response (0..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present; sampled only in IDLE.
- req_we  in  1  1 = store, 0 = load/fetch.
- req_ifetch  in  1  fetch tag; echoed on rsp_ifetch, no other effect.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- busy  out  1  high in every state except IDLE.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_ifetch  out  1  tag of the request being answered.
- rsp_err  out  1  valid with rsp_valid; request was rejected.
- rsp_rdata  out  32  read data, valid with rsp_valid.
- mmio_out  out  32  memory-mapped output register.

## Operation
- States: IDLE, WAIT, RESP. Reset forces IDLE; busy, rsp_valid, rsp_ifetch and rsp_err are 0; rsp_rdata is 0; mmio_out is 0. RAM contents are not reset.
- IDLE: on a clk edge with req_valid=1, latch we/ifetch/addr/wdata. Go to WAIT if WAIT_CYCLES>0, else go to RESP. With req_valid=0, stay in IDLE.
- WAIT: a 4-bit counter loads WAIT_CYCLES-1 on accept and decrements each cycle. At 0, go to RESP.
- Transition into RESP (one edge):
  - Error check: rsp_err=1 when addr[1:0]!=0 or addr[31:ADDR_W+2]!=0.
  - Erroring request: no write occurs; rsp_rdata=0.
  - Legal store: writes RAM[addr[ADDR_W+1:2]]; rsp_rdata=0.
  - Legal load: rsp_rdata=RAM word.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. req_valid in this cycle is ignored.
- No queueing. req_valid while busy=1 is dropped; the requester holds req_valid until it sees rsp_valid.
- Read-after-write to the same word in back-to-back requests returns the new data.
- Reset mid-request (WAIT or RESP) returns to IDLE and drops the response. A store not yet committed is never written.

## Timing
- Accept edge at cycle 0. rsp_valid is high in cycle WAIT_CYCLES+1 and low in cycle WAIT_CYCLES+2, which is back in IDLE.
- Earliest next accept is the edge ending the IDLE cycle after RESP. Throughput is one request per WAIT_CYCLES+3 cycles.
- busy rises the cycle after the accept edge and falls the cycle after RESP.
- All outputs are registered. There is no combinational path from any req_* input to any output.

## Configuration
- MEM_RESPONDER_MMIO_EN defined:
  - Word index all-ones (byte address 4*(2^ADDR_W-1)) maps to mmio_out instead of RAM.
  - A store to that index updates mmio_out on the commit edge.
  - A load from that index returns mmio_out.
- MEM_RESPONDER_MMIO_EN undefined: that word is ordinary RAM, and mmio_out is constant 0.

## Structure
- Shared package mem_pkg holds:
  - state enum (IDLE, WAIT, RESP);
  - DATA_W=32;
  - the helper for the MMIO index, computed from ADDR_W;
  - the error-check function.
- One sub-module, mem_ram: single-port synchronous RAM with write enable and registered read. It is instantiated once and holds no reset logic.

## Test plan
- WAIT_CYCLES=1: store 0xDEADBEEF to 0x10, then load 0x10. Response: rsp_valid in cycle 2 after each accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
- WAIT_CYCLES=0: fetch from 0x0 with req_ifetch=1. Response: rsp_valid in cycle 1, rsp_ifetch=1. busy is high only for the RESP cycle.
- Load 0x6 (misaligned) and load 0x1000 with ADDR_W=10 (out of range). Both give rsp_err=1, rsp_rdata=0. A following load of 0x0 shows RAM unchanged.
- Second req_valid pulse while busy: no second rsp_valid, and RAM is unchanged by the dropped store.
- Store 0x12345678 to 0x20 with WAIT_CYCLES=3, asserting reset in the second WAIT cycle. Result: state IDLE, no rsp_valid, and a later load of 0x20 returns the previous value.
- With MEM_RESPONDER_MMIO_EN, store 0xA5 to 0xFFC. Result: mmio_out=0xA5 from the cycle after the commit edge, and a load of 0xFFC returns 0xA5. Without the macro, mmio_out stays 0.
